hex_display_driver: RTL and testbench
=====================================

Name: hex_display_driver

Overview:
Parametrised multi-digit 7-segment display driver. It is the successor to the single-digit combinational hex encoder. It latches a value on a load strobe and shows it in either hex or decimal; decimal mode uses a sequential double-dabble binary-to-BCD converter. Each digit is driven in parallel and supports leading-zero blanking, forced blanking, blinking and an overflow indication. It sits between the measurement/debug logic and the board's HEX outputs.

Parameters:
N_DIGITS, 6, number of digits driven; value width W = 4*N_DIGITS
BLINK_DIV, 25000000, clk cycles per blink half-period (>=1)
ACTIVE_LOW, 1, 1 = segment on is driven 0 (board default); 0 = active-high

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
load  in  1  single-cycle strobe: capture value/dec_mode
value  in  W  binary value to display
dec_mode  in  1  1 = decimal via BCD conversion, 0 = hex nibbles; sampled only on accepted load
lz_blank  in  1  leading-zero blanking enable (live)
blank_mask  in  N_DIGITS  per-digit forced blank (live), bit i = digit i
blink_mask  in  N_DIGITS  per-digit blink enable (live)
busy  out  1  conversion in progress; load ignored while high
overflow  out  1  decimal value >= 10^N_DIGITS on last accepted load
seg  out  7*N_DIGITS  segment codes; seg[7i+6:7i] = digit i, bit order g..a; digit 0 least significant

Behaviour:
- Reset (async assert, sync release): busy=0, overflow=0, digit registers=0, blink phase=visible, blink counter=0, seg = all segments off (all ones when ACTIVE_LOW=1). Reset during a conversion aborts it.
- Load acceptance: load=1 and busy=0 at edge k. load while busy=1 is ignored, with no queueing.
- Hex mode:
  - Digit regs = value nibbles at edge k+1; overflow cleared at k+1.
  - seg reflects the new value after edge k+2. busy stays 0.
- Decimal mode:
  - busy=1 from edge k+1 for exactly W cycles (shift/add-3 over W bits, one bit per cycle).
  - At edge k+W+1: digit regs written, overflow updated, busy=0.
  - seg updated at edge k+W+2.
  - Display regs keep the previous value during conversion.
  - Overflow is detected from any carry out of the top BCD digit during conversion.
- Overflow=1: every digit shows a dash (segment g only, 0x40) regardless of lz_blank. blank_mask and blink still apply.
- Glyphs (active-high, g..a):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - dash:40, blank:00
  - ACTIVE_LOW=1 inverts all 7 bits.
- Per-digit priority (highest first): blank_mask -> blink (blink_mask bit set and phase=hidden) -> overflow dash -> leading-zero blank -> glyph.
- Leading-zero blanking: with lz_blank=1, digit i is blank iff digit i and all more-significant digits are 0, and i>0. Digit 0 is never LZ-blanked, so value 0 shows "0".
- Live inputs (lz_blank, blank_mask, blink_mask) reach seg with 1-cycle latency. seg is fully registered and glitch-free.
- Blink counter: runs continuously and wraps at BLINK_DIV-1, toggling phase on wrap. Phase is shared by all digits, and is independent of load and busy.

Test Plan:
- N=4, ACTIVE_LOW=1. Hex load 0xBEEF at edge k -> at k+2 seg digits3..0 = ~7C,~79,~79,~71; busy stays 0.
- N=4, dec load 16'd1234 -> busy high exactly 16 cycles. The old display is held throughout. Then seg = ~06,~5B,~4F,~66, overflow=0.
- N=4, dec load 16'd10000 -> after conversion all digits ~40, overflow=1. A subsequent hex load 0x0000 -> overflow=0, "0000".
- lz_blank=1 with hex 0x0007 -> digits3..1 = 7F (off), digit0 = ~07. With 0x0000 -> digit0 = ~3F only. With 0x0100 -> digits 2..0 = ~06,~3F,~3F.
- BLINK_DIV=4, blink_mask=0001 -> digit0 alternates visible/off every 4 cycles, other digits steady. blank_mask=0001 then holds digit0 off continuously.
- Dec load 16'd9999, then load mid-busy (hex 0x1111) -> second load ignored, result "9999". Next run: rst_n low mid-conversion -> busy=0, seg all ones, no late digit update.

Source files
------------

// File: rtl/hex_display_driver.sv
// -----------------------------------------------------------------------------
// hex_display_driver
//
// Multi-digit 7-segment display driver. A value is captured on a load strobe
// and shown either as hex nibbles or, in decimal mode, as BCD digits produced
// by a sequential double-dabble converter (one bit per clock). Every digit is
// driven in parallel, with leading-zero blanking, forced blanking, blinking and
// an overflow dash indication. The seg output is fully registered.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        single-cycle strobe; accepted only while busy is low
//   value       binary value to display (4*N_DIGITS bits)
//   dec_mode    1 = decimal (BCD conversion), 0 = hex; sampled on accepted load
//   lz_blank    leading-zero blanking enable (live)
//   blank_mask  per-digit forced blank (live), bit i = digit i
//   blink_mask  per-digit blink enable (live)
//   busy        decimal conversion in progress
//   overflow    last decimal value did not fit in N_DIGITS digits
//   seg         segment codes, seg[7i+6:7i] = digit i, bit order g..a
// -----------------------------------------------------------------------------
module hex_display_driver #(
    parameter int N_DIGITS   = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    dec_mode,
    input  logic                    lz_blank,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic [N_DIGITS-1:0]     blink_mask,
    output logic                    busy,
    output logic                    overflow,
    output logic [7*N_DIGITS-1:0]   seg
);

    localparam int W  = 4 * N_DIGITS;
    localparam int CW = $clog2(W + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [7*N_DIGITS-1:0] SEG_OFF = {(7*N_DIGITS){ACTIVE_LOW}};

    // S_CAP holds a freshly captured value for one cycle: hex values are
    // written to the digit registers from there, decimal values start shifting.
    typedef enum logic [1:0] {
        S_IDLE,
        S_CAP,
        S_CONV
    } state_t;

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [W-1:0]           bin_q, bin_d;
    logic [W-1:0]           bcd_q, bcd_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   overflow_q, overflow_d;
    logic [W-1:0]           digit_q, digit_d;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   phase_q, phase_d;
    logic [7*N_DIGITS-1:0]  seg_q, seg_d;

    logic                   accept;
    logic [W-1:0]           bcd_adj;
    logic                   step_carry;
    logic [W-1:0]           step_bcd;
    logic [W-1:0]           step_bin;

    logic                   zero_run;
    logic [3:0]             nib;
    logic [6:0]             glyph;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0:    hex_glyph = 7'h3F;
            4'h1:    hex_glyph = 7'h06;
            4'h2:    hex_glyph = 7'h5B;
            4'h3:    hex_glyph = 7'h4F;
            4'h4:    hex_glyph = 7'h66;
            4'h5:    hex_glyph = 7'h6D;
            4'h6:    hex_glyph = 7'h7D;
            4'h7:    hex_glyph = 7'h07;
            4'h8:    hex_glyph = 7'h7F;
            4'h9:    hex_glyph = 7'h6F;
            4'hA:    hex_glyph = 7'h77;
            4'hB:    hex_glyph = 7'h7C;
            4'hC:    hex_glyph = 7'h39;
            4'hD:    hex_glyph = 7'h5E;
            4'hE:    hex_glyph = 7'h79;
            4'hF:    hex_glyph = 7'h71;
            default: hex_glyph = 7'h00;
        endcase
    endfunction

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift the
    // combined {bcd, bin} register left by one. A bit leaving the top BCD
    // digit means the value needs more than N_DIGITS decimal digits.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
        step_carry = bcd_adj[W-1];
        step_bcd   = {bcd_adj[W-2:0], bin_q[W-1]};
        step_bin   = {bin_q[W-2:0], 1'b0};
    end

    // Load / conversion control.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d    = state_q;
        mode_d     = mode_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        digit_d    = digit_q;
        accept     = load && !busy_q;

        unique case (state_q)
            S_CAP: begin
                if (mode_q) begin
                    // First of W shift steps; busy rises with it.
                    bin_d     = step_bin;
                    bcd_d     = step_bcd;
                    ovf_acc_d = ovf_acc_q | step_carry;
                    cnt_d     = cnt_q + CW'(1);
                    busy_d    = 1'b1;
                    state_d   = S_CONV;
                end else begin
                    digit_d    = bin_q;
                    overflow_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_CONV: begin
                if (cnt_q == CW'(W)) begin
                    digit_d    = bcd_q;
                    overflow_d = ovf_acc_q;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    bin_d     = step_bin;
                    bcd_d     = step_bcd;
                    ovf_acc_d = ovf_acc_q | step_carry;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase

        // A load in the capture cycle (busy still low) supersedes a pending
        // decimal start; there is no queueing.
        if (accept) begin
            bin_d     = value;
            bcd_d     = '0;
            ovf_acc_d = 1'b0;
            cnt_d     = '0;
            mode_d    = dec_mode;
            busy_d    = 1'b0;
            state_d   = S_CAP;
        end
    end

    // Free-running blink timebase, shared by all digits. phase 1 = hidden.
    always_comb begin
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            phase_d     = phase_q;
        end
    end

    // Per-digit glyph selection. Digits are walked from the most significant
    // down so zero_run tells whether this digit and all above it are zero.
    always_comb begin
        seg_d    = '0;
        zero_run = 1'b1;
        nib      = '0;
        glyph    = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            nib      = digit_q[4*i +: 4];
            zero_run = zero_run & (nib == 4'd0);
            if (blank_mask[i]) begin
                glyph = 7'h00;
            end else if (blink_mask[i] && phase_q) begin
                glyph = 7'h00;
            end else if (overflow_q) begin
                glyph = 7'h40;
            end else if (lz_blank && zero_run && (i > 0)) begin
                glyph = 7'h00;
            end else begin
                glyph = hex_glyph(nib);
            end
            seg_d[7*i +: 7] = ACTIVE_LOW ? ~glyph : glyph;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            ovf_acc_q   <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            digit_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg_q       <= SEG_OFF;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            ovf_acc_q   <= ovf_acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            digit_q     <= digit_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// -----------------------------------------------------------------------------
// tb_hex_display_driver
//
// Scoreboard bench for hex_display_driver (N_DIGITS=4, BLINK_DIV=4,
// ACTIVE_LOW=1). The stimulus process computes expected outputs from a
// digit-level reference model and queues them tagged with the cycle at which
// they must appear; an independent monitor compares them on falling edges.
// -----------------------------------------------------------------------------
module tb_hex_display_driver;

    localparam int N  = 4;
    localparam int W  = 4 * N;
    localparam int BD = 4;

    localparam int K_SEG  = 0;
    localparam int K_BUSY = 1;
    localparam int K_OVF  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load = 1'b0;
    logic [W-1:0]    value = '0;
    logic            dec_mode = 1'b0;
    logic            lz_blank = 1'b0;
    logic [N-1:0]    blank_mask = '0;
    logic [N-1:0]    blink_mask = '0;
    logic            busy;
    logic            overflow;
    logic [7*N-1:0]  seg;

    hex_display_driver #(
        .N_DIGITS   (N),
        .BLINK_DIV  (BD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dec_mode   (dec_mode),
        .lz_blank   (lz_blank),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .busy       (busy),
        .overflow   (overflow),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             at;
        int             kind;
        logic [7*N-1:0] exp;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   c0    = 0;      // cycle at which reset was last released

    // Reference model state: decimal or hex digits currently displayed.
    int   m_d[N];
    bit   m_ovf;

    logic [7*N-1:0] mon_act;

    task automatic check(input string name, input logic [7*N-1:0] act,
                         input logic [7*N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int at, input int kind,
                             input logic [7*N-1:0] exp, input string name);
        exp_t e;
        e.at   = at;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare everything due on this cycle, flag anything overdue.
    always @(negedge clk) begin
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].at == cyc) begin
                case (sb[i].kind)
                    K_SEG:   mon_act = seg;
                    K_BUSY:  mon_act = {{(7*N-1){1'b0}}, busy};
                    default: mon_act = {{(7*N-1){1'b0}}, overflow};
                endcase
                check(sb[i].name, mon_act, sb[i].exp);
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                total++;
                bad++;
                $display("FAIL %s missed at cyc=%0d", sb[i].name, sb[i].at);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Blink phase visible on seg at cycle 'at': seg is registered from the
    // phase after (at-1-c0) timebase ticks; the phase flips every BD ticks.
    function automatic bit hidden_at(input int at);
        int r;
        r = at - 1 - c0;
        return (r >= 0) && (((r / BD) % 2) == 1);
    endfunction

    function automatic logic [7*N-1:0] model_seg(input bit hidden);
        logic [7*N-1:0] r;
        logic [6:0]     g;
        bit             all_zero_above;
        r = '0;
        for (int i = 0; i < N; i++) begin
            all_zero_above = 1'b1;
            for (int j = i; j < N; j++) all_zero_above &= (m_d[j] == 0);
            if (blank_mask[i])                        g = 7'h00;
            else if (blink_mask[i] && hidden)         g = 7'h00;
            else if (m_ovf)                           g = 7'h40;
            else if (lz_blank && all_zero_above && i > 0) g = 7'h00;
            else                                      g = ref_glyph(m_d[i]);
            r[7*i +: 7] = ~g;
        end
        return r;
    endfunction

    function automatic logic [7*N-1:0] seg_now(input int at);
        return model_seg(hidden_at(at));
    endfunction

    task automatic model_load(input int v, input bit dec);
        int p;
        p = 1;
        if (dec && v >= 10 ** N) begin
            m_ovf = 1'b1;
        end else begin
            m_ovf = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_d[i] = dec ? (v / p) % 10 : (v >> (4 * i)) & 15;
                p = p * 10;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_d[i] = 0;
        m_ovf = 1'b0;
    endtask

    task automatic pulse_load(input logic [W-1:0] v, input bit dec);
        value    = v;
        dec_mode = dec;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        dec_mode = 1'b0;
    endtask

    // Hex load driven at cycle c: digits written one edge after acceptance,
    // seg one edge later; busy never rises.
    task automatic hex_op(input logic [W-1:0] v, input string tag);
        int c;
        logic [7*N-1:0] old_s;
        c = cyc;
        old_s = seg_now(c + 2);
        model_load(int'(v), 1'b0);
        expect_at(c + 2, K_SEG,  old_s,          {tag, " old"});
        expect_at(c + 3, K_SEG,  seg_now(c + 3), {tag, " seg"});
        expect_at(c + 2, K_BUSY, '0,             {tag, " busy"});
        expect_at(c + 3, K_OVF,  '0,             {tag, " ovf"});
        pulse_load(v, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    // Decimal load driven at cycle c: busy high for exactly W cycles, old
    // display held meanwhile. Optional extra hex load 'inject' cycles later.
    task automatic dec_op(input logic [W-1:0] v, input string tag, input int inject);
        int c;
        logic [7*N-1:0] old_s;
        c = cyc;
        old_s = seg_now(c + 2);
        model_load(int'(v), 1'b1);
        expect_at(c + 1, K_BUSY, '0, {tag, " busy pre"});
        for (int j = 2; j <= W + 1; j++) expect_at(c + j, K_BUSY, 1, {tag, " busy win"});
        expect_at(c + W + 2, K_BUSY, '0, {tag, " busy end"});
        expect_at(c + 2,     K_SEG, old_s, {tag, " hold start"});
        expect_at(c + W + 2, K_SEG, old_s, {tag, " hold end"});
        expect_at(c + W + 2, K_OVF, {{(7*N-1){1'b0}}, m_ovf}, {tag, " ovf"});
        expect_at(c + W + 3, K_SEG, seg_now(c + W + 3), {tag, " seg"});
        pulse_load(v, 1'b1);
        while (cyc < c + W + 4) begin
            if (inject > 0 && cyc == c + inject) pulse_load(16'h1111, 1'b0);
            else @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [W-1:0] rv;
        bit           rd;

        model_reset();
        repeat (2) @(negedge clk);
        expect_at(cyc + 1, K_SEG,  '1, "reset seg");
        expect_at(cyc + 1, K_BUSY, '0, "reset busy");
        expect_at(cyc + 1, K_OVF,  '0, "reset ovf");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        expect_at(cyc + 1, K_SEG, {4{~7'h3F}}, "post-reset 0000");
        @(negedge clk);

        // Hex glyphs b, E, E, F.
        expect_at(cyc + 3, K_SEG, {~7'h7C, ~7'h79, ~7'h79, ~7'h71}, "BEEF const");
        hex_op(16'hBEEF, "hex BEEF");

        // Decimal 1234.
        expect_at(cyc + W + 3, K_SEG, {~7'h06, ~7'h5B, ~7'h4F, ~7'h66}, "1234 const");
        dec_op(16'd1234, "dec 1234", 0);

        // Decimal overflow, then hex load clears it.
        expect_at(cyc + W + 3, K_SEG, {4{~7'h40}}, "10000 dashes");
        expect_at(cyc + W + 2, K_OVF, 1, "10000 ovf const");
        dec_op(16'd10000, "dec 10000", 0);
        expect_at(cyc + 3, K_SEG, {4{~7'h3F}}, "hex 0 after ovf");
        hex_op(16'h0000, "hex 0000");

        // Leading-zero blanking.
        lz_blank = 1'b1;
        expect_at(cyc + 3, K_SEG, {7'h7F, 7'h7F, 7'h7F, ~7'h07}, "lz 0007 const");
        hex_op(16'h0007, "lz 0007");
        expect_at(cyc + 3, K_SEG, {7'h7F, 7'h7F, 7'h7F, ~7'h3F}, "lz 0000 const");
        hex_op(16'h0000, "lz 0000");
        expect_at(cyc + 3, K_SEG, {7'h7F, ~7'h06, ~7'h3F, ~7'h3F}, "lz 0100 const");
        hex_op(16'h0100, "lz 0100");
        expect_at(cyc + W + 3, K_SEG, {4{~7'h40}}, "lz ovf dashes");
        dec_op(16'd54321, "lz dec ovf", 0);
        lz_blank = 1'b0;

        // Blinking on digit 0, then forced blank on digit 0.
        hex_op(16'h1234, "pre-blink");
        c = cyc;
        blink_mask = 4'b0001;
        for (int j = 1; j <= 16; j++) expect_at(c + j, K_SEG, seg_now(c + j), "blink");
        repeat (17) @(negedge clk);
        c = cyc;
        blank_mask = 4'b0001;
        for (int j = 1; j <= 8; j++) expect_at(c + j, K_SEG, seg_now(c + j), "blank over blink");
        repeat (9) @(negedge clk);
        c = cyc;
        blink_mask = '0;
        blank_mask = '0;
        expect_at(c + 1, K_SEG, {~7'h06, ~7'h5B, ~7'h4F, ~7'h66}, "masks cleared");
        repeat (2) @(negedge clk);

        // Randomized loads against the reference model.
        for (int n = 0; n < 12; n++) begin
            rd = 1'($urandom_range(0, 1));
            if (rd && $urandom_range(0, 1) == 1) rv = W'($urandom_range(0, 9999));
            else                                 rv = W'($urandom_range(0, 65535));
            lz_blank   = 1'($urandom_range(0, 1));
            blank_mask = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            if (rd) dec_op(rv, "rand dec", 0);
            else    hex_op(rv, "rand hex");
        end
        lz_blank   = 1'b0;
        blank_mask = '0;
        @(negedge clk);

        // Load while busy is ignored.
        expect_at(cyc + W + 3, K_SEG, {4{~7'h6F}}, "9999 const");
        dec_op(16'd9999, "dec 9999 w/ ignored load", 8);

        // Reset in the middle of a conversion.
        c = cyc;
        expect_at(c + 1, K_BUSY, '0, "abort busy pre");
        for (int j = 2; j <= 5; j++) expect_at(c + j, K_BUSY, 1, "abort busy win");
        pulse_load(16'd4321, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        expect_at(c + 6, K_SEG,  '1, "abort seg off");
        expect_at(c + 6, K_BUSY, '0, "abort busy");
        expect_at(c + 6, K_OVF,  '0, "abort ovf");
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        model_reset();
        expect_at(c + W + 3, K_BUSY, '0, "abort no late busy");
        expect_at(c + W + 4, K_SEG, {4{~7'h3F}}, "abort no late update");
        expect_at(c + W + 8, K_SEG, seg_now(c + W + 8), "abort steady");
        repeat (W + 10) @(negedge clk);

        repeat (3) @(negedge clk);
        foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL %s never compared (due cyc=%0d)", sb[i].name, sb[i].at);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
